// File: rtl/synth_step_sequencer_if.sv
// Sweep-controller request/status signals and synthesizer serial pins.
// The master modport is the sweep-controller side; the slave modport is the sequencer.
interface synth_step_sequencer_if;
    logic       step;
    logic       step_reset;
    logic       busy;
    logic       done;
    logic [7:0] step_index;
    logic       err_overrun;
    logic       spi_clk;
    logic       spi_data;
    logic       spi_le;

    modport master (
        output step, step_reset,
        input  busy, done, step_index, err_overrun, spi_clk, spi_data, spi_le
    );

    modport slave (
        input  step, step_reset,
        output busy, done, step_index, err_overrun, spi_clk, spi_data, spi_le
    );
endinterface

// File: rtl/synth_step_sequencer.sv
// Tracks the sweep step index and N divider, and programs the synthesizer
// with a 24-bit {REG_ADDR, N} word over a 3-wire serial port per request.
module synth_step_sequencer #(
    parameter int          NUM_STEPS = 37,
    parameter logic [15:0] BASE_N    = 16'd800,
    parameter logic [15:0] STEP_N    = 16'd4,
    parameter logic [7:0]  REG_ADDR  = 8'h02,
    parameter int          CLK_DIV   = 4
) (
    input logic                  clock,
    input logic                  reset,
    synth_step_sequencer_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] CLK_LO = 3'd2;
    localparam logic [2:0] CLK_HI = 3'd3;
    localparam logic [2:0] LATCH  = 3'd4;

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]     IDX_LAST = 8'(NUM_STEPS - 1);

    logic [2:0]       state;
    logic [7:0]       idx;
    logic [15:0]      n_acc;
    logic             pending;
    logic             err;
    logic [22:0]      shreg;
    logic [4:0]       bitcnt;
    logic [DIV_W-1:0] divcnt;
    logic             busy_q;
    logic             done_q;
    logic             sclk_q;
    logic             sdata_q;
    logic             le_q;
    logic             req;
    logic             div_end;

    assign req     = bus.step | bus.step_reset;
    assign div_end = (divcnt == DIV_LAST);

    // Request decode and depth-1 pending flag; a request on the same edge
    // the FSM leaves IDLE keeps the flag set so it is not lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx     <= '0;
            n_acc   <= BASE_N;
            pending <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            if (req) begin
                if (bus.step_reset || idx == IDX_LAST) begin
                    idx   <= '0;
                    n_acc <= BASE_N;
                end else begin
                    idx   <= idx + 8'd1;
                    n_acc <= n_acc + STEP_N;
                end
                pending <= 1'b1;
                err     <= pending;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end
        end
    end

    // The bit on the wire lives in sdata_q, so shreg only holds the remaining 23 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            divcnt  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) state <= LOAD;
                end
                LOAD: begin
                    shreg   <= {REG_ADDR[6:0], n_acc};
                    sdata_q <= REG_ADDR[7];
                    bitcnt  <= 5'd23;
                    busy_q  <= 1'b1;
                    divcnt  <= '0;
                    sclk_q  <= 1'b0;
                    state   <= CLK_LO;
                end
                CLK_LO: begin
                    if (div_end) begin
                        divcnt <= '0;
                        sclk_q <= 1'b1;
                        state  <= CLK_HI;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                CLK_HI: begin
                    if (div_end) begin
                        divcnt <= '0;
                        sclk_q <= 1'b0;
                        if (bitcnt == 5'd0) begin
                            sdata_q <= 1'b0;
                            le_q    <= 1'b1;
                            state   <= LATCH;
                        end else begin
                            sdata_q <= shreg[22];
                            shreg   <= {shreg[21:0], 1'b0};
                            bitcnt  <= bitcnt - 5'd1;
                            state   <= CLK_LO;
                        end
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        divcnt <= '0;
                        le_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.step_index  = idx;
    assign bus.err_overrun = err;
    assign bus.spi_clk     = sclk_q;
    assign bus.spi_data    = sdata_q;
    assign bus.spi_le      = le_q;

endmodule

// File: tb/tb_synth_step_sequencer.sv
// Self-checking bench for synth_step_sequencer: serial-word monitors plus an
// index/N reference model computed as BASE_N + index*STEP_N (mod 2^16).
module tb_synth_step_sequencer;

    localparam int CLK_DIV = 4;
    localparam int LAT     = 2 + 49 * CLK_DIV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    synth_step_sequencer_if bus1();
    synth_step_sequencer_if bus2();

    synth_step_sequencer #(
        .NUM_STEPS(37), .BASE_N(16'd800), .STEP_N(16'd4), .REG_ADDR(8'h02), .CLK_DIV(CLK_DIV)
    ) dut (.clock(clock), .reset(reset), .bus(bus1));

    synth_step_sequencer #(
        .NUM_STEPS(37), .BASE_N(16'h0001), .STEP_N(16'hFFFF), .REG_ADDR(8'h02), .CLK_DIV(CLK_DIV)
    ) dut_wrap (.clock(clock), .reset(reset), .bus(bus2));

    int checks = 0;
    int fails  = 0;
    int m_idx  = 0;

    // Monitor for the main instance.
    logic [23:0] words1[$];
    int          nbits1[$];
    int          le1[$];
    logic [23:0] sh1 = '0;
    int cur_bits1 = 0, cur_le1 = 0, errcnt1 = 0, donecnt1 = 0, glitch1 = 0;
    logic p_clk1 = 0, p_le1 = 0, p_data1 = 0;

    always @(negedge clock) begin
        if (reset) begin
            sh1 = '0; cur_bits1 = 0; cur_le1 = 0;
            p_clk1 = 0; p_le1 = 0; p_data1 = 0;
        end else begin
            if (bus1.spi_clk && !p_clk1) begin
                sh1 = {sh1[22:0], bus1.spi_data};
                cur_bits1++;
            end
            if (bus1.spi_clk && p_clk1 && bus1.spi_data !== p_data1) glitch1++;
            if (bus1.spi_le) cur_le1++;
            if (!bus1.spi_le && p_le1) begin
                words1.push_back(sh1);
                nbits1.push_back(cur_bits1);
                le1.push_back(cur_le1);
                sh1 = '0; cur_bits1 = 0; cur_le1 = 0;
            end
            if (bus1.err_overrun) errcnt1++;
            if (bus1.done) donecnt1++;
            p_clk1 = bus1.spi_clk; p_le1 = bus1.spi_le; p_data1 = bus1.spi_data;
        end
    end

    // Monitor for the 16-bit-wrap instance.
    logic [23:0] words2[$];
    logic [23:0] sh2 = '0;
    logic p_clk2 = 0, p_le2 = 0;

    always @(negedge clock) begin
        if (reset) begin
            sh2 = '0; p_clk2 = 0; p_le2 = 0;
        end else begin
            if (bus2.spi_clk && !p_clk2) sh2 = {sh2[22:0], bus2.spi_data};
            if (!bus2.spi_le && p_le2) begin
                words2.push_back(sh2);
                sh2 = '0;
            end
            p_clk2 = bus2.spi_clk; p_le2 = bus2.spi_le;
        end
    end

    function automatic logic [23:0] exp_word(input int idx, input int base, input int stepn);
        int n;
        n = (base + idx * stepn) % 65536;
        return {8'h02, n[15:0]};
    endfunction

    function automatic logic [23:0] last_word1();
        return (words1.size() > 0) ? words1[words1.size()-1] : 24'hxxxxxx;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic model_request(input bit s, input bit r);
        if (r || (s && m_idx == 36)) m_idx = 0;
        else if (s) m_idx++;
    endtask

    task automatic pulse1(input bit s, input bit r);
        bus1.step = s; bus1.step_reset = r;
        tick();
        bus1.step = 1'b0; bus1.step_reset = 1'b0;
        model_request(s, r);
    endtask

    task automatic wait_done(input bit sel, output int cycles, output bit timeout, output bit saw_busy);
        cycles = 0; saw_busy = 0;
        while (!(sel ? bus2.done : bus1.done) && cycles < 1000) begin
            tick();
            cycles++;
            if (sel ? bus2.busy : bus1.busy) saw_busy = 1;
        end
        timeout = !(sel ? bus2.done : bus1.done);
    endtask

    task automatic do_transfer(input bit s, input bit r, output int lat, output bit to, output bit sb);
        pulse1(s, r);
        wait_done(1'b0, lat, to, sb);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus1.busy, bus1.done, bus1.err_overrun, bus1.spi_clk, bus1.spi_data, bus1.spi_le} !== 6'b0) begin
            fails++; $display("FAIL reset_outputs: got %b expected 000000",
                {bus1.busy, bus1.done, bus1.err_overrun, bus1.spi_clk, bus1.spi_data, bus1.spi_le});
        end
        checks++;
        if (bus1.step_index !== 8'd0) begin
            fails++; $display("FAIL reset_index: got %0d expected 0", bus1.step_index);
        end
        checks++;
        if ({bus2.busy, bus2.spi_clk, bus2.spi_le, bus2.step_index} !== 11'b0) begin
            fails++; $display("FAIL reset_outputs_wrap: got %h expected 0",
                {bus2.busy, bus2.spi_clk, bus2.spi_le, bus2.step_index});
        end
        reset = 1'b0;
        m_idx = 0;
        tick();
    endtask

    task automatic test_single_program();
        int lat; bit to, sb;
        words1.delete();
        do_transfer(1'b0, 1'b1, lat, to, sb);
        checks++;
        if (to || lat != LAT) begin
            fails++; $display("FAIL single_latency: got %0d expected %0d (timeout=%0b)", lat, LAT, to);
        end
        tick();
        checks++;
        if (words1.size() != 1 || last_word1() !== 24'h020320) begin
            fails++; $display("FAIL single_word: got %h (count %0d) expected 020320", last_word1(), words1.size());
        end
        checks++;
        if (nbits1.size() != 1 || nbits1[0] != 24) begin
            fails++; $display("FAIL single_bitcount: got %0d expected 24", nbits1.size() > 0 ? nbits1[0] : -1);
        end
        checks++;
        if (le1.size() != 1 || le1[0] != CLK_DIV) begin
            fails++; $display("FAIL single_le_width: got %0d expected %0d", le1.size() > 0 ? le1[0] : -1, CLK_DIV);
        end
        checks++;
        if (!sb || bus1.busy !== 1'b0) begin
            fails++; $display("FAIL single_busy: got saw_busy=%0b busy_after=%b expected 1 and 0", sb, bus1.busy);
        end
        checks++;
        if (bus1.step_index !== 8'd0) begin
            fails++; $display("FAIL single_index: got %0d expected 0", bus1.step_index);
        end
        checks++;
        if (glitch1 != 0) begin
            fails++; $display("FAIL data_stable: got %0d changes expected 0", glitch1);
        end
    endtask

    task automatic test_sweep_wrap();
        int lat; bit to, sb;
        for (int k = 1; k <= 37; k++) begin
            words1.delete();
            do_transfer(1'b1, 1'b0, lat, to, sb);
            tick();
            checks++;
            if (to || words1.size() != 1 || last_word1() !== exp_word(m_idx, 800, 4)) begin
                fails++; $display("FAIL sweep_word[%0d]: got %h expected %h", k, last_word1(), exp_word(m_idx, 800, 4));
            end
            checks++;
            if (bus1.step_index !== 8'(m_idx)) begin
                fails++; $display("FAIL sweep_index[%0d]: got %0d expected %0d", k, bus1.step_index, m_idx);
            end
            if (k == 36) begin
                checks++;
                if (last_word1() !== 24'h0203B0 || bus1.step_index !== 8'd36) begin
                    fails++; $display("FAIL sweep_last: got %h idx %0d expected 0203b0 idx 36", last_word1(), bus1.step_index);
                end
            end
            if (k == 37) begin
                checks++;
                if (last_word1() !== 24'h020320 || bus1.step_index !== 8'd0) begin
                    fails++; $display("FAIL sweep_wrap: got %h idx %0d expected 020320 idx 0", last_word1(), bus1.step_index);
                end
            end
        end
        checks++;
        if (glitch1 != 0) begin
            fails++; $display("FAIL sweep_data_stable: got %0d changes expected 0", glitch1);
        end
    endtask

    task automatic test_simultaneous();
        int lat; bit to, sb; int e0;
        for (int k = 0; k < 5; k++) do_transfer(1'b1, 1'b0, lat, to, sb);
        tick();
        checks++;
        if (bus1.step_index !== 8'd5) begin
            fails++; $display("FAIL simul_setup: got %0d expected 5", bus1.step_index);
        end
        e0 = errcnt1;
        words1.delete();
        do_transfer(1'b1, 1'b1, lat, to, sb);
        tick();
        checks++;
        if (to || last_word1() !== 24'h020320 || bus1.step_index !== 8'd0) begin
            fails++; $display("FAIL simul_priority: got %h idx %0d expected 020320 idx 0", last_word1(), bus1.step_index);
        end
        checks++;
        if (errcnt1 != e0) begin
            fails++; $display("FAIL simul_no_overrun: got %0d pulses expected 0", errcnt1 - e0);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit to, sb, to2; int e0, d0;
        words1.delete();
        e0 = errcnt1; d0 = donecnt1;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) repeat (9) tick();
            pulse1(1'b1, 1'b0);
        end
        checks++;
        if (bus1.err_overrun !== 1'b1) begin
            fails++; $display("FAIL overrun_timing: got %b expected 1", bus1.err_overrun);
        end
        wait_done(1'b0, lat, to, sb);
        tick();
        wait_done(1'b0, lat, to2, sb);
        checks++;
        if (to || to2) begin
            fails++; $display("FAIL b2b_done: got timeouts %0b/%0b expected 0/0", to, to2);
        end
        repeat (30) tick();
        checks++;
        if (words1.size() != 2 || donecnt1 - d0 != 2) begin
            fails++; $display("FAIL b2b_count: got %0d words %0d dones expected 2 and 2", words1.size(), donecnt1 - d0);
        end
        checks++;
        if (words1.size() < 2 || words1[0] !== exp_word(1, 800, 4) || words1[1] !== exp_word(3, 800, 4)) begin
            fails++; $display("FAIL b2b_words: got %h %h expected %h %h",
                words1.size() > 0 ? words1[0] : 24'hx, last_word1(), exp_word(1, 800, 4), exp_word(3, 800, 4));
        end
        checks++;
        if (errcnt1 - e0 != 1) begin
            fails++; $display("FAIL b2b_overrun_count: got %0d expected 1", errcnt1 - e0);
        end
        checks++;
        if (bus1.step_index !== 8'd3) begin
            fails++; $display("FAIL b2b_index: got %0d expected 3", bus1.step_index);
        end
    endtask

    task automatic test_reset_midway();
        int lat, n; bit to, sb; int d0;
        pulse1(1'b1, 1'b0);
        n = 0;
        while (cur_bits1 < 10 && n < 1000) begin tick(); n++; end
        checks++;
        if (cur_bits1 != 10) begin
            fails++; $display("FAIL midway_reach: got %0d bits expected 10", cur_bits1);
        end
        words1.delete();
        d0 = donecnt1;
        reset = 1'b1;
        tick();
        m_idx = 0;
        checks++;
        if ({bus1.spi_clk, bus1.spi_le, bus1.spi_data, bus1.busy, bus1.done} !== 5'b0 || bus1.step_index !== 8'd0) begin
            fails++; $display("FAIL midway_abort: got %b idx %0d expected 00000 idx 0",
                {bus1.spi_clk, bus1.spi_le, bus1.spi_data, bus1.busy, bus1.done}, bus1.step_index);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (300) tick();
        checks++;
        if (donecnt1 != d0 || words1.size() != 0) begin
            fails++; $display("FAIL midway_no_done: got %0d dones %0d words expected 0 and 0", donecnt1 - d0, words1.size());
        end
        do_transfer(1'b0, 1'b1, lat, to, sb);
        tick();
        checks++;
        if (to || last_word1() !== 24'h020320) begin
            fails++; $display("FAIL midway_reprogram: got %h expected 020320", last_word1());
        end
    endtask

    task automatic test_wrap16();
        int lat; bit to, sb;
        words2.delete();
        bus2.step = 1'b1;
        tick();
        bus2.step = 1'b0;
        wait_done(1'b1, lat, to, sb);
        tick();
        checks++;
        if (to || words2.size() != 1 || (words2.size() > 0 && words2[0] !== exp_word(1, 1, 65535))) begin
            fails++; $display("FAIL wrap16_word: got %h expected %h",
                words2.size() > 0 ? words2[0] : 24'hx, exp_word(1, 1, 65535));
        end
    endtask

    task automatic test_random();
        int lat, kind; bit to, sb, s, r;
        for (int k = 0; k < 20; k++) begin
            kind = int'($urandom_range(0, 5));
            r = (kind == 0) || (kind == 1);
            s = (kind != 0);
            repeat ($urandom_range(0, 5)) tick();
            words1.delete();
            do_transfer(s, r, lat, to, sb);
            tick();
            checks++;
            if (to || lat != LAT || last_word1() !== exp_word(m_idx, 800, 4)) begin
                fails++; $display("FAIL random_word[%0d]: got %h lat %0d expected %h lat %0d",
                    k, last_word1(), lat, exp_word(m_idx, 800, 4), LAT);
            end
            checks++;
            if (bus1.step_index !== 8'(m_idx)) begin
                fails++; $display("FAIL random_index[%0d]: got %0d expected %0d", k, bus1.step_index, m_idx);
            end
        end
    endtask

    initial begin
        bus1.step = 1'b0; bus1.step_reset = 1'b0;
        bus2.step = 1'b0; bus2.step_reset = 1'b0;
        test_reset();
        test_single_program();
        test_sweep_wrap();
        test_simultaneous();
        test_back_to_back();
        test_reset_midway();
        test_wrap16();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
